// File: rtl/spi_cal_eeprom.sv
// Calibration EEPROM model: 64 x 8 storage behind an oversampled mode-0 SPI slave port.
// Optional write protect input enabled by defining EEP_WRT_PROT_EN.
module spi_cal_eeprom #(
    parameter int unsigned       ADDR_W   = 6,
    parameter int unsigned       DATA_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = 8'h00
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
`ifdef EEP_WRT_PROT_EN
    input  logic wrt_prot,
`endif
    output logic MISO
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned FRAME_W = 2 + ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
    localparam int unsigned CNT_MAX = FRAME_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic ss_q1, ss_q2, ss_q3;
    logic sclk_q1, sclk_q2, sclk_q3;
    logic mosi_q1, mosi_q2;

    logic [FRAME_W-1:0] rx_shft;
    logic [FRAME_W-1:0] tx_shft;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  rd_buf;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic load_tx, sh_in, sh_out, do_wr, do_rd;
    logic wr_block;

    logic [1:0]        rx_op;
    logic [ADDR_W-1:0] rx_addr;
    logic [DATA_W-1:0] rx_data;

    assign rx_op   = rx_shft[FRAME_W-1 -: 2];
    assign rx_addr = rx_shft[DATA_W +: ADDR_W];
    assign rx_data = rx_shft[DATA_W-1:0];

`ifdef EEP_WRT_PROT_EN
    assign wr_block = wrt_prot;
`else
    assign wr_block = 1'b0;
`endif

    // SS_n sync flops reset low so a select already held low at reset release
    // never looks like a fresh fall; only a rise followed by a new fall starts a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_q1   <= 1'b0;
            ss_q2   <= 1'b0;
            ss_q3   <= 1'b0;
            sclk_q1 <= 1'b0;
            sclk_q2 <= 1'b0;
            sclk_q3 <= 1'b0;
            mosi_q1 <= 1'b0;
            mosi_q2 <= 1'b0;
        end else begin
            ss_q1   <= SS_n;
            ss_q2   <= ss_q1;
            ss_q3   <= ss_q2;
            sclk_q1 <= SCLK;
            sclk_q2 <= sclk_q1;
            sclk_q3 <= sclk_q2;
            mosi_q1 <= MOSI;
            mosi_q2 <= mosi_q1;
        end
    end

    assign ss_fall   =  ss_q3   & ~ss_q2;
    assign ss_rise   = ~ss_q3   &  ss_q2;
    assign sclk_rise = ~sclk_q3 &  sclk_q2;
    assign sclk_fall =  sclk_q3 & ~sclk_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall) state_nxt = SHIFT;
            SHIFT:   if (ss_rise) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Deselect wins over a coincident SCLK edge; only exact-length frames execute.
    always_comb begin
        load_tx = 1'b0;
        sh_in   = 1'b0;
        sh_out  = 1'b0;
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        case (state)
            IDLE:  load_tx = ss_fall;
            SHIFT: begin
                if (!ss_rise) begin
                    sh_in  = sclk_rise;
                    sh_out = sclk_fall;
                end
            end
            EXEC: begin
                if (cnt == CNT_W'(FRAME_W)) begin
                    do_wr = (rx_op == 2'b01) && !wr_block;
                    do_rd = (rx_op == 2'b00);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_shft <= '0;
            tx_shft <= '0;
            cnt     <= '0;
            rd_buf  <= '0;
            MISO    <= 1'b0;
        end else begin
            if (load_tx) begin
                cnt     <= '0;
                tx_shft <= FRAME_W'(rd_buf);
            end
            if (sh_in) begin
                rx_shft <= {rx_shft[FRAME_W-2:0], mosi_q2};
                if (cnt != CNT_W'(CNT_MAX)) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (sh_out) begin
                tx_shft <= {tx_shft[FRAME_W-2:0], 1'b0};
            end
            if (do_rd) begin
                rd_buf <= mem[rx_addr];
            end
            MISO <= ~ss_q2 & tx_shft[FRAME_W-1];
        end
    end

    // Storage array; every location returns to INIT_VAL on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_VAL;
            end
        end else if (do_wr) begin
            mem[rx_addr] <= rx_data;
        end
    end

endmodule

// File: tb/tb_spi_cal_eeprom.sv
// Self-checking bench for spi_cal_eeprom: SPI master tasks with an expected-MISO scoreboard queue.
module tb_spi_cal_eeprom;

    logic clk;
    logic rst;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;
`ifdef EEP_WRT_PROT_EN
    logic wrt_prot;
`endif

    int checks;
    int failures;
    logic [15:0] exp_q[$];

    spi_cal_eeprom dut (
        .clk  (clk),
        .rst  (rst),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI),
`ifdef EEP_WRT_PROT_EN
        .wrt_prot (wrt_prot),
`endif
        .MISO (MISO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One SPI mode-0 frame of nbits; optional reset pulse before bit rst_at.
    task automatic run_frame(input logic [15:0] word, input int nbits, input int rst_at,
                             output logic [15:0] rx);
        rx = '0;
        @(negedge clk);
        SS_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? word[15-i] : 1'b0;
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
            repeat (6) @(negedge clk);
            if (i < 16) rx[15-i] = MISO;
            SCLK = 1'b1;
            repeat (6) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (6) @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Checked frame: expectation is queued before the frame is driven.
    task automatic test_frame(input string name, input logic [15:0] word, input logic [15:0] exp);
        logic [15:0] rx;
        logic [15:0] e;
        exp_q.push_back(exp);
        run_frame(word, 16, -1, rx);
        e = exp_q.pop_front();
        checks++;
        if (rx !== e) begin
            failures++;
            $display("FAIL %s: word=%h miso got=%h exp=%h", name, word, rx, e);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (MISO !== 1'b0) begin
            failures++;
            $display("FAIL reset_miso: got=%b exp=0", MISO);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        test_frame("reset_rd0_a", 16'h0000, 16'h0000);
        test_frame("reset_rd0_b", 16'h0000, 16'h0000);
    endtask

    task automatic test_write_read();
        test_frame("wr_0a",        16'h4A5C, 16'h0000);
        test_frame("rd_0a",        16'h0A00, 16'h0000);
        test_frame("rd_09_get_0a", 16'h0900, 16'h005C);
        test_frame("rd_0b_get_09", 16'h0B00, 16'h0000);
        test_frame("rd_00_get_0b", 16'h0000, 16'h0000);
    endtask

    task automatic test_extremes();
        test_frame("wr_3f_ff",     16'h7FFF, 16'h0000);
        test_frame("wr_00_81",     16'h4081, 16'h0000);
        test_frame("rd_3f",        16'h3F00, 16'h0000);
        test_frame("rd_00_get_3f", 16'h0000, 16'h00FF);
        test_frame("rd_3f_get_00", 16'h3F00, 16'h0081);
    endtask

    task automatic test_bad_frames();
        logic [15:0] rx;
        test_frame("rd_0a_get_3f", 16'h0A00, 16'h00FF);
        run_frame(16'h0900, 15, -1, rx);
        run_frame(16'h4A77, 17, -1, rx);
        // SCLK activity while deselected must be ignored
        MOSI = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (5) @(negedge clk);
            SCLK = ~SCLK;
        end
        MOSI = 1'b0;
        repeat (5) @(negedge clk);
        test_frame("bad_keep_rdbuf", 16'h0A00, 16'h005C);
        test_frame("bad_keep_mem",   16'h0B00, 16'h005C);
    endtask

    task automatic test_back_to_back();
        test_frame("b2b_wr_33",    16'h6A33, 16'h0000);
        test_frame("b2b_rd_2a",    16'h2A00, 16'h0000);
        test_frame("b2b_wr_c4",    16'h6AC4, 16'h0033);
        test_frame("b2b_rd_2a_2",  16'h2A00, 16'h0033);
        test_frame("b2b_get_c4",   16'h0B00, 16'h00C4);
        test_frame("reserved_op",  16'hAA55, 16'h0000);
        test_frame("rsv_rd_2a",    16'h2A00, 16'h0000);
        test_frame("rsv_get_2a",   16'h0B00, 16'h00C4);
    endtask

    task automatic test_rst_mid_frame();
        logic [15:0] rx;
        run_frame(16'h45A5, 16, 8, rx);
        test_frame("rst_rd_05",     16'h0500, 16'h0000);
        test_frame("rst_rd_3f",     16'h3F00, 16'h0000);
        test_frame("rst_get_3f",    16'h0000, 16'h0000);
        test_frame("rst_wr_05",     16'h453C, 16'h0000);
        test_frame("rst_rd_05_b",   16'h0500, 16'h0000);
        test_frame("rst_get_05",    16'h0000, 16'h003C);
    endtask

`ifdef EEP_WRT_PROT_EN
    task automatic test_wrt_prot();
        wrt_prot = 1'b1;
        test_frame("wp_wr_11",    16'h51AA, 16'h0000);
        test_frame("wp_rd_11",    16'h1100, 16'h0000);
        test_frame("wp_get_11",   16'h0000, 16'h0000);
        wrt_prot = 1'b0;
        test_frame("nwp_wr_11",   16'h51AA, 16'h0000);
        test_frame("nwp_rd_11",   16'h1100, 16'h0000);
        test_frame("nwp_get_11",  16'h0000, 16'h00AA);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
`ifdef EEP_WRT_PROT_EN
        wrt_prot = 1'b0;
`endif
        test_reset();
        test_write_read();
        test_extremes();
        test_bad_frames();
        test_back_to_back();
        test_rst_mid_frame();
`ifdef EEP_WRT_PROT_EN
        test_wrt_prot();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_cal_eeprom.md
Name: spi_cal_eeprom

Overview:
- Behavioural/synthesizable model of the DSO calibration EEPROM: 64 x 8-bit storage on a 4-wire SPI slave port (SS_n, SCLK, MOSI, MISO).
- Sits beside the digital core on the shared SPI bus. The core reads per-channel gain/offset calibration bytes from it and writes them back on host request.
- All SPI inputs are oversampled by the system clock; SCLK is never used as a clock.

Parameters:
- ADDR_W, 6, address width; depth = 2**ADDR_W.
- DATA_W, 8, data width per location.
- INIT_VAL, 8'h00, value loaded into every location on reset.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- SS_n  input  1  slave select, active low.
- SCLK  input  1  SPI clock, mode 0 (idle low, sample rising, shift falling).
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.

Behaviour:
- Input synchronisation
  - SS_n, SCLK and MOSI each pass through 2 flops.
  - A third SCLK flop gives rise/fall detect; a third SS_n flop gives fall/rise detect. All decisions use the synchronised signals.
  - SCLK high and low phases must each be >= 4 clk.
- Frame format: 16 bits, MSB first.
  - [15:14] opcode: 00 = read, 01 = write, 1x = reserved (ignored).
  - [13:8] address.
  - [7:0] data (write) or don't-care (read).
- States: IDLE, SHIFT, EXEC.
  - IDLE -> SHIFT on SS_n fall: bit counter cleared, MISO shift register loaded with {8'h00, rd_buf}.
  - SHIFT, SCLK rise: shift MOSI into rx_shft[0]; counter increments and saturates at 17.
  - SHIFT, SCLK fall: shift MISO register left, filling with 0.
  - SHIFT -> EXEC on SS_n rise.
  - EXEC (1 clk): if counter == 16, decode rx_shft. Otherwise discard the frame (short or long frame), leaving memory and rd_buf untouched. Then return to IDLE.
- Write: mem[addr] <= data in the EXEC cycle. rd_buf is unchanged.
- Read: rd_buf <= mem[addr] in the EXEC cycle. The byte appears on MISO bits [7:0] of the next frame, so a read costs two frames.
- Write then read of the same address in back-to-back frames returns the newly written value.
- MISO = shift register MSB while SS_n (sync) is low; 0 while deselected.
- Reset: every mem location = INIT_VAL; rd_buf = 0; shift registers = 0; counter = 0; state = IDLE; MISO = 0.
  - Reset mid-frame aborts the frame with no memory update.
  - After reset, a frame starts only on a fresh SS_n fall. If SS_n is already low when rst deasserts, the block waits for SS_n high and then a new fall.
- SCLK edges while SS_n is high are ignored.
- SS_n rise and SCLK edge in the same clk: the SS_n rise takes priority and the SCLK edge is dropped.
- Address range is full 0..63; no wrap logic is needed.

Optional Feature:
- Macro EEP_WRT_PROT_EN.
- When defined: adds input port wrt_prot (1 bit). While wrt_prot = 1 in the EXEC cycle, write frames are discarded; reads are unaffected.
- When not defined: the port does not exist and all valid write frames update memory.

Test Plan:
- Reset then read addr 6'h00 (frame 16'h0000, then frame 16'h0000) -> second frame's MISO returns 16'h0000 (INIT_VAL).
- Write 16'h4A5C (addr 0x0A, data 0x5C); read 16'h0A00; then a dummy frame -> MISO returns 16'h005C; addresses 0x09 and 0x0B still read 0x00.
- Write 0x3F <- 0xFF and 0x00 <- 0x81; read both -> 0xFF and 0x81 (extreme addresses and data).
- 15-bit frame 0x4A7 ... (write pattern) and 17-bit frame -> location unchanged and rd_buf unchanged.
- Assert rst in the middle of a write frame to 0x05 -> 0x05 reads INIT_VAL; the next complete frame works normally.
- With EEP_WRT_PROT_EN and wrt_prot = 1: write 0x11 <- 0xAA -> reads 0x00. With wrt_prot = 0: the same write reads 0xAA.
